// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-strobed data RAM.
// Holds the state encoding, the byte width and the per-lane merge used by write and bypass.
package ram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ram_state_t;

  localparam int BYTE_W = 8;

  function automatic logic [BYTE_W-1:0] merge_bytes(
    input logic [BYTE_W-1:0] old_byte,
    input logic [BYTE_W-1:0] new_byte,
    input logic              strb
  );
    return strb ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/strobe_sync_ram.sv
// Synchronous byte-strobed data RAM with valid/ready read and write ports.
// Clears itself after reset and reports misaligned or out-of-range accesses.
module strobe_sync_ram
  import ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_done,
  input  logic                     rd_req_valid,
  output logic                     rd_req_ready,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W/BYTE_W-1:0] rd_strb,
  output logic                     rd_resp_valid,
  input  logic                     rd_resp_ready,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_err,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/BYTE_W-1:0] wr_strb,
  output logic                     wr_err
);

  localparam int NB     = DATA_W / BYTE_W;
  localparam int LSB_SH = $clog2(NB);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(NB - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  ram_state_t        state_r;
  ram_state_t        state_next_s;
  logic [IDX_W-1:0]  init_cnt_r;
  logic              run_s;

  logic              rd_resp_valid_r;
  logic              rd_err_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              wr_err_r;

  logic [ADDR_W-1:0] wr_word_s;
  logic              wr_ok_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic              wr_fire_s;
  logic              wr_commit_s;
  logic [DATA_W-1:0] wr_old_s;
  logic [DATA_W-1:0] wr_merge_s;

  logic [ADDR_W-1:0] rd_word_s;
  logic              rd_ok_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic              rd_fire_s;
  logic              rd_bypass_s;
  logic [DATA_W-1:0] rd_old_s;
  logic [DATA_W-1:0] rd_next_s;

  assign run_s         = (state_r == RUN);
  assign init_done     = run_s;
  assign wr_ready      = run_s;
  assign rd_req_ready  = run_s && (!rd_resp_valid_r || rd_resp_ready);
  assign rd_resp_valid = rd_resp_valid_r;
  assign rd_err        = rd_err_r;
  assign rd_data       = rd_data_r;
  assign wr_err        = wr_err_r;

  // Word index is kept at full address width so high bits fail the range check.
  assign wr_word_s   = wr_addr >> LSB_SH;
  assign wr_ok_s     = ((wr_addr & ALIGN_MASK) == {ADDR_W{1'b0}}) && (wr_word_s < DEPTH_A);
  assign wr_idx_s    = wr_word_s[IDX_W-1:0];
  assign wr_fire_s   = wr_valid && run_s;
  assign wr_commit_s = wr_fire_s && wr_ok_s && !rst;
  assign wr_old_s    = mem[wr_idx_s];

  assign rd_word_s   = rd_addr >> LSB_SH;
  assign rd_ok_s     = ((rd_addr & ALIGN_MASK) == {ADDR_W{1'b0}}) && (rd_word_s < DEPTH_A);
  assign rd_idx_s    = rd_word_s[IDX_W-1:0];
  assign rd_fire_s   = rd_req_valid && rd_req_ready;
  assign rd_bypass_s = wr_commit_s && (wr_idx_s == rd_idx_s);
  assign rd_old_s    = mem[rd_idx_s];

  // Next-state logic: sweep every word once, then serve traffic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      INIT: begin
        if (init_cnt_r == IDX_W'(DEPTH - 1)) begin
          state_next_s = RUN;
        end else begin
          state_next_s = INIT;
        end
      end
      RUN:     state_next_s = RUN;
      default: state_next_s = INIT;
    endcase
  end

  // State register and clear-sweep counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= INIT;
      init_cnt_r <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (state_r == INIT) begin
        init_cnt_r <= init_cnt_r + IDX_W'(1);
      end else begin
        init_cnt_r <= init_cnt_r;
      end
    end
  end

  // Byte-lane merge of the incoming write into the addressed word.
  always_comb begin
    wr_merge_s = wr_old_s;
    for (int i = 0; i < NB; i++) begin
      wr_merge_s[i*BYTE_W +: BYTE_W] = merge_bytes(wr_old_s[i*BYTE_W +: BYTE_W],
                                                   wr_data[i*BYTE_W +: BYTE_W], wr_strb[i]);
    end
  end

  // Read data: write-first forwarding per lane, then zero the unrequested lanes.
  always_comb begin
    logic [BYTE_W-1:0] fwd_b;
    fwd_b     = {BYTE_W{1'b0}};
    rd_next_s = {DATA_W{1'b0}};
    if (rd_ok_s) begin
      for (int i = 0; i < NB; i++) begin
        fwd_b = merge_bytes(rd_old_s[i*BYTE_W +: BYTE_W], wr_data[i*BYTE_W +: BYTE_W],
                            rd_bypass_s && wr_strb[i]);
        rd_next_s[i*BYTE_W +: BYTE_W] = merge_bytes({BYTE_W{1'b0}}, fwd_b, rd_strb[i]);
      end
    end else begin
      rd_next_s = {DATA_W{1'b0}};
    end
  end

  // Storage: cleared by the sweep, otherwise written by legal accepted writes.
  always_ff @(posedge clk) begin
    if (!rst && (state_r == INIT)) begin
      mem[init_cnt_r] <= {DATA_W{1'b0}};
    end else if (wr_commit_s) begin
      mem[wr_idx_s] <= wr_merge_s;
    end
  end

  // Read response register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_resp_valid_r <= 1'b0;
      rd_err_r        <= 1'b0;
      rd_data_r       <= {DATA_W{1'b0}};
    end else if (rd_fire_s) begin
      rd_resp_valid_r <= 1'b1;
      rd_err_r        <= !rd_ok_s;
      rd_data_r       <= rd_next_s;
    end else if (rd_resp_ready) begin
      rd_resp_valid_r <= 1'b0;
      rd_err_r        <= 1'b0;
      rd_data_r       <= {DATA_W{1'b0}};
    end else begin
      rd_resp_valid_r <= rd_resp_valid_r;
      rd_err_r        <= rd_err_r;
      rd_data_r       <= rd_data_r;
    end
  end

  // Write error pulse for an accepted but illegal write.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err_r <= 1'b0;
    end else begin
      wr_err_r <= wr_fire_s && !wr_ok_s;
    end
  end

endmodule

// File: tb/tb_strobe_sync_ram.sv
// Scoreboard bench for strobe_sync_ram: stimulus pushes expected read responses,
// a negedge monitor pops and compares each accepted response.
module tb_strobe_sync_ram;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;
  localparam int NB     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              init_done;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [NB-1:0]     rd_strb;
  logic              rd_resp_valid;
  logic              rd_resp_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NB-1:0]     wr_strb;
  logic              wr_err;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t exp_q[$];
  int n_cmp = 0;
  int n_mis = 0;
  int n_pop = 0;

  always #5 clk = ~clk;

  strobe_sync_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
    .rd_strb(rd_strb), .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
    .rd_data(rd_data), .rd_err(rd_err),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .wr_err(wr_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: every accepted read response is checked against the scoreboard.
  always @(negedge clk) begin
    resp_t e;
    if (rd_resp_valid && rd_resp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL rd_unexpected: got data 0x%08h err %0b, expected no response", rd_data, rd_err);
      end else begin
        e = exp_q.pop_front();
        n_pop++;
        check("rd_data", rd_data, e.data);
        check("rd_err", {31'd0, rd_err}, {31'd0, e.err});
      end
    end
  end

  task automatic rd_issue(input logic [31:0] a, input logic [3:0] s, input logic [31:0] ed, input logic ee);
    int t;
    resp_t r;
    t = 0;
    rd_req_valid = 1'b1;
    rd_addr = a;
    rd_strb = s;
    @(negedge clk);
    while (!rd_req_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!rd_req_ready) begin
      timeout("rd_accept");
    end else begin
      r.data = ed;
      r.err = ee;
      exp_q.push_back(r);
    end
    @(posedge clk);
    #1;
    rd_req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) timeout("rd_drain");
    @(posedge clk);
    #1;
  endtask

  task automatic rd_single(input logic [31:0] a, input logic [3:0] s, input logic [31:0] ed, input logic ee);
    rd_issue(a, s, ed, ee);
    check("rd_latency", {31'd0, rd_resp_valid}, 32'd1);
    drain();
  endtask

  task automatic wr_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic ee);
    int t;
    t = 0;
    wr_valid = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_strb = s;
    @(negedge clk);
    while (!wr_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!wr_ready) timeout("wr_accept");
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    check("wr_err", {31'd0, wr_err}, {31'd0, ee});
  endtask

  task automatic rw_same(input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                         input logic [31:0] ra, input logic [3:0] rs, input logic [31:0] ed);
    int t;
    resp_t r;
    t = 0;
    wr_valid = 1'b1; wr_addr = wa; wr_data = wd; wr_strb = ws;
    rd_req_valid = 1'b1; rd_addr = ra; rd_strb = rs;
    @(negedge clk);
    while (!(wr_ready && rd_req_ready) && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!(wr_ready && rd_req_ready)) begin
      timeout("rw_accept");
    end else begin
      r.data = ed;
      r.err = 1'b0;
      exp_q.push_back(r);
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    rd_req_valid = 1'b0;
    check("rw_wr_err", {31'd0, wr_err}, 32'd0);
    drain();
  endtask

  task automatic wait_init();
    int cnt;
    cnt = 0;
    do begin
      @(posedge clk);
      cnt++;
      #1;
    end while (!init_done && cnt < 200);
    check("init_cycles", cnt, 32'd64);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1;
    rd_req_valid = 1'b0; rd_addr = 32'd0; rd_strb = 4'd0; rd_resp_ready = 1'b1;
    wr_valid = 1'b0; wr_addr = 32'd0; wr_data = 32'd0; wr_strb = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_rd_req_ready", {31'd0, rd_req_ready}, 32'd0);
    check("rst_rd_resp_valid", {31'd0, rd_resp_valid}, 32'd0);
    check("rst_rd_err", {31'd0, rd_err}, 32'd0);
    check("rst_wr_err", {31'd0, wr_err}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    rst = 1'b0;
    wait_init();

    for (int i = 0; i < DEPTH; i++) rd_single(32'(i * 4), 4'hF, 32'h0000_0000, 1'b0);

    wr_issue(32'h0C, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    wr_issue(32'h0C, 32'h0000_00AA, 4'b0001, 1'b0);
    rd_single(32'h0C, 4'b1111, 32'hDEAD_BEAA, 1'b0);
    rd_single(32'h0C, 4'b0110, 32'h00AD_BE00, 1'b0);

    wr_issue(32'h10, 32'hAABB_CCDD, 4'b1111, 1'b0);
    rw_same(32'h10, 32'h1122_3344, 4'b0011, 32'h10, 4'b1111, 32'hAABB_3344);
    rd_single(32'h10, 4'b1111, 32'hAABB_3344, 1'b0);

    wr_issue(32'h0E, 32'hFFFF_FFFF, 4'b1111, 1'b1);
    wr_issue(32'h100, 32'hFFFF_FFFF, 4'b1111, 1'b1);
    wr_issue(32'h8000_0000, 32'hFFFF_FFFF, 4'b1111, 1'b1);
    wr_issue(32'h0C, 32'h0000_0000, 4'b0000, 1'b0);
    rd_single(32'h0C, 4'b1111, 32'hDEAD_BEAA, 1'b0);
    rd_single(32'h00, 4'b1111, 32'h0000_0000, 1'b0);
    rd_single(32'h101, 4'b1111, 32'h0000_0000, 1'b1);
    rd_single(32'h0E, 4'b1111, 32'h0000_0000, 1'b1);
    rd_single(32'h8000_000C, 4'b1111, 32'h0000_0000, 1'b1);
    wr_issue(32'hFC, 32'h5A5A_A5A5, 4'b1111, 1'b0);
    rd_single(32'hFC, 4'b1111, 32'h5A5A_A5A5, 1'b0);

    wr_issue(32'h00, 32'h1111_1111, 4'b1111, 1'b0);
    wr_issue(32'h04, 32'h2222_2222, 4'b1111, 1'b0);
    wr_issue(32'h08, 32'h3333_3333, 4'b1111, 1'b0);
    base = n_pop;
    fork
      begin
        rd_issue(32'h00, 4'b1111, 32'h1111_1111, 1'b0);
        rd_issue(32'h04, 4'b1111, 32'h2222_2222, 1'b0);
        rd_issue(32'h08, 4'b1111, 32'h3333_3333, 1'b0);
      end
      begin
        int t;
        t = 0;
        do begin
          @(posedge clk);
          #1;
          t++;
        end while (!(n_pop == base + 1 && rd_resp_valid) && t < 50);
        if (t >= 50) timeout("stall_point");
        rd_resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rd_resp_ready = 1'b1;
      end
    join
    drain();
    check("stream_count", n_pop - base, 32'd3);

    rd_resp_ready = 1'b0;
    rd_issue(32'h04, 4'b1111, 32'h2222_2222, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("midrst_rd_resp_valid", {31'd0, rd_resp_valid}, 32'd0);
    check("midrst_init_done", {31'd0, init_done}, 32'd0);
    rst = 1'b0;
    rd_resp_ready = 1'b1;
    wait_init();
    rd_single(32'h04, 4'b1111, 32'h0000_0000, 1'b0);
    rd_single(32'h0C, 4'b1111, 32'h0000_0000, 1'b0);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL leftover: got %0d pending responses, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
